// File: rtl/umai_mem_responder.sv
// UMAI memory responder: the far-end target for UMAI write/read command bursts.
// One command is served at a time (IDLE -> WRITE or READ -> IDLE). Write and
// read commands are arbitrated round-robin, with write winning the first tie.
// 512-bit beats are stored in a word array. Read data is registered and is
// streamed with full-throughput valid/ready handshakes.

module umai_mem_responder #(
   parameter int Depth     = 1024,  // number of words, power of two, >= 2
   parameter int DataWidth = 512,   // beat width
   parameter int AddrLsb   = 6      // byte-address bit where the word index starts
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_umai_wcmd_valid,
   output logic                 o_umai_wcmd_ready,
   input  logic [31:0]          i_umai_wcmd_addr,
   input  logic [5:0]           i_umai_wcmd_len,
   input  logic                 i_umai_rcmd_valid,
   output logic                 o_umai_rcmd_ready,
   input  logic [31:0]          i_umai_rcmd_addr,
   input  logic [5:0]           i_umai_rcmd_len,
   input  logic                 i_umai_wvalid,
   output logic                 o_umai_wready,
   input  logic [DataWidth-1:0] i_umai_wdata,
   output logic                 o_umai_rvalid,
   input  logic                 i_umai_rready,
   output logic [DataWidth-1:0] o_umai_rdata,
   output logic                 o_busy
);

   localparam int IdxW = $clog2(Depth);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t               state;
   logic                 prio_w;     // 1: write wins the next tie
   logic [IdxW-1:0]      idx;        // current word index inside the burst
   logic [5:0]           count;      // beats left after the current one
   logic                 rvalid_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 busy_q;

   logic [DataWidth-1:0] mem [Depth];

   logic                 grant_w;
   logic                 grant_r;
   logic                 in_idle;
   logic                 w_fire;
   logic                 r_fire;
   logic [IdxW-1:0]      wcmd_idx;
   logic [IdxW-1:0]      rcmd_idx;

   // Only the word-index bits of each address are used. Bits below AddrLsb and
   // above the index are ignored, so indices wrap modulo Depth. The unused
   // bits are folded into this signal so that they are visibly consumed.
   logic                 unused_addr_bits;
   assign unused_addr_bits = ^{i_umai_wcmd_addr, i_umai_rcmd_addr};

   assign wcmd_idx = i_umai_wcmd_addr[AddrLsb +: IdxW];
   assign rcmd_idx = i_umai_rcmd_addr[AddrLsb +: IdxW];

   // The command readies are forced low while reset is held, so that every
   // output is 0 during reset even if the master keeps its valids high.
   assign in_idle = (state == ST_IDLE) && i_rst_n;

   // Round-robin arbitration between the write and read command channels.
   // NOTE: every signal assigned in always_comb gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      grant_w = 1'b0;
      grant_r = 1'b0;
      grant_w = i_umai_wcmd_valid && (!i_umai_rcmd_valid || prio_w);
      grant_r = i_umai_rcmd_valid && !grant_w;
   end

   assign o_umai_wcmd_ready = in_idle && grant_w;
   assign o_umai_rcmd_ready = in_idle && grant_r;
   assign o_umai_wready     = (state == ST_WRITE);
   assign o_umai_rvalid     = rvalid_q;
   assign o_umai_rdata      = rdata_q;
   assign o_busy            = busy_q;

   assign w_fire = i_umai_wvalid && o_umai_wready;
   assign r_fire = rvalid_q && i_umai_rready;

   // Burst FSM. It also owns the registered read data, read valid and busy.
   // NOTE: state is updated with non-blocking assignments only, so every
   // right-hand side sees the values from before this clock edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         prio_w   <= 1'b1;
         idx      <= '0;
         count    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A tie is always accepted in the same cycle, so it flips priority.
               if (i_umai_wcmd_valid && i_umai_rcmd_valid) begin
                  prio_w <= !prio_w;
               end
               if (grant_w) begin
                  state  <= ST_WRITE;
                  busy_q <= 1'b1;
                  idx    <= wcmd_idx;
                  count  <= i_umai_wcmd_len;
               end else if (grant_r) begin
                  // The first beat is presented in the cycle after acceptance.
                  state    <= ST_READ;
                  busy_q   <= 1'b1;
                  rvalid_q <= 1'b1;
                  rdata_q  <= mem[rcmd_idx];
                  idx      <= rcmd_idx + IdxW'(1);
                  count    <= i_umai_rcmd_len;
               end
            end

            ST_WRITE: begin
               if (w_fire) begin
                  idx <= idx + IdxW'(1);
                  if (count == 6'd0) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     count <= count - 6'd1;
                  end
               end
            end

            ST_READ: begin
               // rdata and rvalid hold while the master stalls.
               if (r_fire) begin
                  if (count == 6'd0) begin
                     state    <= ST_IDLE;
                     busy_q   <= 1'b0;
                     rvalid_q <= 1'b0;
                  end else begin
                     rdata_q <= mem[idx];
                     idx     <= idx + IdxW'(1);
                     count   <= count - 6'd1;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               busy_q   <= 1'b0;
               rvalid_q <= 1'b0;
            end
         endcase
      end
   end

   // Word array write port. Beats are only accepted in the WRITE state.
   // NOTE: the array has no reset, so it can map onto SRAM. Its contents are
   // undefined until written, and an async reset never clears them.
   always_ff @(posedge i_clk) begin
      if (w_fire) begin
         mem[idx] <= i_umai_wdata;
      end
   end

endmodule

// File: tb/tb_umai_mem_responder.sv
// Self-checking bench for umai_mem_responder. The reference model is a plain
// word array indexed by (byte address / 64) mod depth. Expected grants, beat
// order and end-of-burst behaviour come from the bench's own bookkeeping.

module tb_umai_mem_responder;

   localparam int DEPTH = 1024;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wcmd_valid = 1'b0;
   logic         wcmd_ready;
   logic [31:0]  wcmd_addr = '0;
   logic [5:0]   wcmd_len = '0;
   logic         rcmd_valid = 1'b0;
   logic         rcmd_ready;
   logic [31:0]  rcmd_addr = '0;
   logic [5:0]   rcmd_len = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [511:0] wdata = '0;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [511:0] rdata;
   logic         busy;

   int errors = 0;
   int checks = 0;

   logic [511:0] model_mem [DEPTH];
   logic [511:0] wbuf [64];

   umai_mem_responder #(.Depth(DEPTH), .DataWidth(512), .AddrLsb(6)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_umai_wcmd_valid (wcmd_valid),
      .o_umai_wcmd_ready (wcmd_ready),
      .i_umai_wcmd_addr  (wcmd_addr),
      .i_umai_wcmd_len   (wcmd_len),
      .i_umai_rcmd_valid (rcmd_valid),
      .o_umai_rcmd_ready (rcmd_ready),
      .i_umai_rcmd_addr  (rcmd_addr),
      .i_umai_rcmd_len   (rcmd_len),
      .i_umai_wvalid     (wvalid),
      .o_umai_wready     (wready),
      .i_umai_wdata      (wdata),
      .o_umai_rvalid     (rvalid),
      .i_umai_rready     (rready),
      .o_umai_rdata      (rdata),
      .o_busy            (busy)
   );

   always #5 clk = ~clk;

   // Watchdog: a hung run still reports before stopping.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a >> 6) % DEPTH;
   endfunction

   function automatic logic [511:0] rand_beat();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic wcmd(input logic [31:0] addr, input int len);
      int n;
      n = 0;
      wcmd_valid = 1'b1;
      wcmd_addr  = addr;
      wcmd_len   = 6'(len);
      #1;
      while (!wcmd_ready && n < 50) begin
         step();
         n++;
      end
      check("wcmd_ready", wcmd_ready, 1);
      step();
      wcmd_valid = 1'b0;
   endtask

   task automatic rcmd(input logic [31:0] addr, input int len);
      int n;
      n = 0;
      rcmd_valid = 1'b1;
      rcmd_addr  = addr;
      rcmd_len   = 6'(len);
      #1;
      while (!rcmd_ready && n < 50) begin
         step();
         n++;
      end
      check("rcmd_ready", rcmd_ready, 1);
      check("rvalid_at_accept", rvalid, 0);
      step();
      rcmd_valid = 1'b0;
   endtask

   // Send beats wbuf[0..len], optionally with idle gaps, and update the model.
   task automatic wr_beats(input int idx0, input int len, input bit gaps);
      for (int b = 0; b <= len; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            wvalid = 1'b0;
            #1;
            check("wready_gap", wready, 1);
            step();
         end
         wvalid = 1'b1;
         wdata  = wbuf[b];
         #1;
         check("wready", wready, 1);
         check("busy_w", busy, 1);
         step();
         model_mem[(idx0 + b) % DEPTH] = wbuf[b];
      end
      wvalid = 1'b0;
      #1;
      check("wready_end", wready, 0);
      check("busy_w_end", busy, 0);
   endtask

   // mode 0: rready always 1; mode 1: random rready; mode 2: rready 1,0,0,1 repeating
   task automatic rd_beats(input int idx0, input int len, input int mode);
      int b;
      int cyc;
      bit rr;
      b = 0;
      cyc = 0;
      while (b <= len && cyc < 500) begin
         case (mode)
            0:       rr = 1'b1;
            1:       rr = 1'($urandom_range(0, 1));
            default: rr = (cyc % 4 == 0) || (cyc % 4 == 3);
         endcase
         rready = rr;
         #1;
         check("rvalid", rvalid, 1);
         check("rdata", rdata, model_mem[(idx0 + b) % DEPTH]);
         check("busy_r", busy, 1);
         step();
         if (rr) b++;
         cyc++;
      end
      check("rd_beats", b, len + 1);
      rready = 1'b0;
      #1;
      check("rvalid_end", rvalid, 0);
      check("rdata_hold", rdata, model_mem[(idx0 + len) % DEPTH]);
      check("busy_r_end", busy, 0);
   endtask

   task automatic wr_burst(input logic [31:0] addr, input int len, input bit gaps);
      wcmd(addr, len);
      wr_beats(widx(addr), len, gaps);
   endtask

   task automatic rd_burst(input logic [31:0] addr, input int len, input int mode);
      rcmd(addr, len);
      rd_beats(widx(addr), len, mode);
   endtask

   initial begin
      // Reset with every input asserted: all outputs must still be 0.
      wcmd_valid = 1'b1;
      rcmd_valid = 1'b1;
      wvalid     = 1'b1;
      rready     = 1'b1;
      repeat (3) step();
      check("rst_wcmd_ready", wcmd_ready, 0);
      check("rst_rcmd_ready", rcmd_ready, 0);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);

      // Release with both commands pending: write wins the first tie.
      wvalid    = 1'b0;
      rready    = 1'b0;
      wcmd_addr = 32'h0000_0100;
      wcmd_len  = 6'd3;
      rcmd_addr = 32'h0000_0100;
      rcmd_len  = 6'd3;
      rst_n     = 1'b1;
      #1;
      check("tie_wcmd_ready", wcmd_ready, 1);
      check("tie_rcmd_ready", rcmd_ready, 0);
      step();
      wcmd_valid = 1'b0;
      rcmd_valid = 1'b0;
      #1;
      check("write_cmd_ready_low", wcmd_ready, 0);
      for (int i = 0; i < 4; i++) wbuf[i] = rand_beat();
      wr_beats(widx(32'h0000_0100), 3, 1'b0);

      // Read back A0..A3 with no stalls, then with the 1,0,0,1 stall pattern.
      rd_burst(32'h0000_0100, 3, 0);
      rd_burst(32'h0000_0100, 1, 2);

      // Index wrap: word 1023 followed by word 0.
      wbuf[0] = rand_beat();
      wbuf[1] = rand_beat();
      wr_burst(32'h0000_FFC0, 1, 1'b0);
      rd_burst(32'h0000_0000, 0, 0);
      check("wrap_word0", model_mem[0], wbuf[1]);
      rd_burst(32'h0000_FFC0, 1, 1);

      // Reset during the third beat of a 64-beat read.
      for (int i = 0; i < 64; i++) wbuf[i] = rand_beat();
      wr_burst(32'h0000_2000, 63, 1'b0);
      rcmd(32'h0000_2000, 63);
      rready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         #1;
         check("pre_rst_rdata", rdata, model_mem[(widx(32'h0000_2000) + b) % DEPTH]);
         step();
      end
      #1;
      check("pre_rst_rvalid", rvalid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rdata", rdata, 0);
      rready = 1'b0;
      step();
      rst_n      = 1'b1;
      wcmd_valid = 1'b1;
      wcmd_addr  = 32'h0000_3000;
      wcmd_len   = 6'd0;
      #1;
      check("post_rst_wcmd_ready", wcmd_ready, 1);
      wbuf[0] = rand_beat();
      wr_burst(32'h0000_3000, 0, 1'b0);
      rd_burst(32'h0000_3000, 0, 0);
      rd_burst(32'h0000_2000, 3, 1);

      // Round-robin with both command valids held high: W, R, W, R.
      wcmd_valid = 1'b1;
      wcmd_addr  = 32'h0000_4040;
      wcmd_len   = 6'd0;
      rcmd_valid = 1'b1;
      rcmd_addr  = 32'h0000_4040;
      rcmd_len   = 6'd0;
      for (int k = 0; k < 4; k++) begin
         bit exp_w;
         int n;
         exp_w = (k % 2 == 0);
         n = 0;
         #1;
         while (!(wcmd_ready || rcmd_ready) && n < 50) begin
            step();
            n++;
         end
         check("rr_wcmd_ready", wcmd_ready, exp_w);
         check("rr_rcmd_ready", rcmd_ready, !exp_w);
         step();
         check("rr_cmd_ready_in_burst", {wcmd_ready, rcmd_ready}, 0);
         check("rr_busy", busy, 1);
         if (exp_w) begin
            wbuf[0] = rand_beat();
            wr_beats(widx(32'h0000_4040), 0, 1'b0);
         end else begin
            rd_beats(widx(32'h0000_4040), 0, 0);
         end
      end
      wcmd_valid = 1'b0;
      rcmd_valid = 1'b0;

      // Randomized write/read-back bursts, including stalls and write gaps.
      for (int t = 0; t < 8; t++) begin
         logic [31:0] a;
         int len;
         a   = $urandom;
         len = $urandom_range(0, 15);
         for (int i = 0; i <= len; i++) wbuf[i] = rand_beat();
         wr_burst(a, len, 1'b1);
         rd_burst(a, len, 1);
      end
      rd_burst(32'h0000_0100, 3, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/umai_mem_responder.md
Name: umai_mem_responder

Overview:
Single-port memory responder that terminates a UMAI master interface. It is the far end of the command/data traffic issued on o_umai_mst_* by the chiplet bridge, and serves as the on-chip loopback target and the verification target for the AIB link. It accepts write and read bursts, stores 512-bit beats in a flop/SRAM array, and returns read data with full-throughput valid/ready handshakes.

Parameters:
Depth, 1024, number of 512-bit words; must be a power of two, minimum 2.
DataWidth, 512, beat width; fixed by UMAI.
AddrLsb, 6, byte-address bit where the word index starts; 64-byte beats.

Ports:
i_clk  input  1  single clock for all logic
i_rst_n  input  1  asynchronous active-low reset
i_umai_wcmd_valid  input  1  write command valid
o_umai_wcmd_ready  output  1  write command accepted
i_umai_wcmd_addr  input  32  write byte address
i_umai_wcmd_len  input  6  write burst length minus one (1..64 beats)
i_umai_rcmd_valid  input  1  read command valid
o_umai_rcmd_ready  output  1  read command accepted
i_umai_rcmd_addr  input  32  read byte address
i_umai_rcmd_len  input  6  read burst length minus one
i_umai_wvalid  input  1  write beat valid
o_umai_wready  output  1  write beat accepted
i_umai_wdata  input  512  write beat data
o_umai_rvalid  output  1  read beat valid
i_umai_rready  input  1  read beat accepted
o_umai_rdata  output  512  read beat data
o_busy  output  1  high in WRITE or READ state

Behaviour:
- Clock/reset: one clock i_clk; reset is asynchronous and active-low on i_rst_n. During reset, all outputs are 0, state is IDLE, and write priority is set. Memory contents are not reset and are undefined until written.
- Word index = addr[AddrLsb +: log2(Depth)]. Address bits below AddrLsb are ignored. Higher bits are ignored, so the index wraps modulo Depth. Within a burst, the index increments by 1 per beat and wraps from Depth-1 to 0.
- Beat count = len+1. len=0 is 1 beat; len=63 is 64 beats.
- FSM states: IDLE, WRITE, READ.
- IDLE arbitration:
  - grant_w = wcmd_valid && (!rcmd_valid || prio_w).
  - grant_r = rcmd_valid && !grant_w.
  - o_umai_wcmd_ready = IDLE && grant_w; o_umai_rcmd_ready = IDLE && grant_r. These are combinational from the valids.
  - On acceptance, latch the index and count, then go to WRITE or READ.
  - prio_w toggles only when both valids were high in the same accepting cycle. This gives round-robin, with write first after reset.
  - In WRITE and READ, both cmd_ready outputs are 0.
- WRITE:
  - o_umai_wready = 1.
  - On each wvalid&&wready: mem[idx] <= wdata, idx++, count--.
  - The handshake of the last beat returns the FSM to IDLE. wready is 0 on the next cycle.
  - Beats arriving while in IDLE or READ are not accepted (wready=0).
- READ:
  - If the command is accepted in cycle N, o_umai_rvalid=1 from cycle N+1 with rdata = mem[first idx].
  - rdata/rvalid are registered. They hold stable while rvalid && !rready.
  - On each rvalid&&rready, the next beat is presented in the following cycle. Zero bubbles: one beat per cycle when rready is held high.
  - The handshake of the last beat goes to IDLE. rvalid=0 on the next cycle; rdata holds its last value.
  - A new command can be accepted in the cycle after the FSM returns to IDLE.
  - Minimum turnaround is 1 idle cycle between bursts.
- Ordering/coherence: bursts are strictly serialized. A read issued after a write completes returns the written data. There is no read/write overlap, so there is no hazard.
- o_busy = (state != IDLE), registered from state.
- Reset mid-burst: the FSM returns to IDLE immediately and rvalid drops asynchronously. Partially written words keep the beats already written. Remaining beats are dropped, and the master is expected to be reset too.

Test Plan:
- Reset: hold i_rst_n=0 -> all outputs 0 and o_busy=0. Release, present wcmd and rcmd together -> wcmd_ready=1 and rcmd_ready=0 in the same cycle (write priority).
- Write addr=0x0000_0100 len=3 with data A0..A3, then read the same address, len=3, rready=1 -> rvalid first in cycle N+1, A0..A3 on 4 consecutive cycles, then rvalid=0.
- Read len=1 with rready toggling 1,0,0,1 -> rdata held stable while stalled, exactly 2 beats delivered in order.
- Wrap: Depth=1024, write addr=0x0000_FFC0 (index 1023) len=1 -> words 1023 and 0 written; a read of addr=0 len=0 returns the second beat.
- Round-robin: keep both cmd valids high across 4 commands -> grant order is W, R, W, R; o_busy is high during each burst.
- Reset asserted during the 3rd beat of a 64-beat read -> rvalid=0 immediately; after release, IDLE accepts a new command at once.
